spi_xfer_seq: RTL and testbench
===============================

# spi_xfer_seq

Command sequencer that sits directly upstream of the generic SPI master. It buffers write/read commands in a small FIFO and drives the master's req/ack handshake: hold request until ack, drop request, wait for ack to clear. It frames each transfer with a chip-select (cs_n) whose setup, hold and inter-transfer gap are programmable. Read results are returned on a single-entry valid/ready response port.

## Interface
- DEPTH, 4: command FIFO depth; power of two, 2..16.
- TIMEOUT_CYC, 65535: maximum cycles in REQ before abort. Used only with the timeout option.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command push strobe.
- cmd_ready  out  1  FIFO not full.
- cmd_wr  in  1  command includes a write (shift out cmd_data).
- cmd_rd  in  1  command includes a read (capture response).
- cmd_data  in  32  write word.
- n_setup, n_hold, n_gap  in  8 each  cs_n setup/hold/gap in clk cycles; static while busy.
- m_wr_req, m_rd_req  out  1 each  request to master.
- m_wr_data  out  32  write word to master; stable from request assertion through ack.
- m_ack  in  1  master acknowledge.
- m_rd_data  in  32  master read word.
- m_rst  out  1  one-cycle reset pulse for master (timeout abort only).
- cs_n  out  1  chip select, active-low.
- rsp_valid  out  1  read response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  32  read word.
- rsp_err  out  1  response belongs to an aborted transfer.
- busy  out  1  FSM not in IDLE, or FIFO not empty.

## Operation
- Reset values: cs_n=1. The following are 0: m_wr_req, m_rd_req, m_wr_data, m_rst, rsp_valid, rsp_data, rsp_err, busy. FIFO is empty; cmd_ready=1.
- FIFO push when cmd_valid&&cmd_ready. A push while full is ignored (cmd_ready=0). Push and pop in the same cycle are legal.
- FSM states: IDLE, SETUP, REQ, DROP, HOLD, GAP.
- IDLE
  - Pop when FIFO is non-empty and, if head cmd_rd=1, rsp_valid=0.
  - Head with cmd_wr=cmd_rd=0 is popped and discarded; stay in IDLE with no cs activity.
  - Otherwise latch the command, set cs_n=0 and m_wr_data=cmd_data.
  - Go to SETUP, or to REQ if n_setup=0.
- SETUP: cs_n low for n_setup cycles, then go to REQ.
- REQ: m_wr_req=cmd_wr and m_rd_req=cmd_rd, held until a cycle with m_ack=1. In that cycle:
  - Deassert both requests.
  - If cmd_rd: load rsp_data=m_rd_data, set rsp_valid=1, rsp_err=0.
  - Go to DROP.
- DROP: wait for m_ack=0, then go to HOLD (or to GAP if n_hold=0).
- HOLD: cs_n low for n_hold cycles, then cs_n=1 and go to GAP (or IDLE if n_gap=0).
- GAP: cs_n high for n_gap cycles, then go to IDLE.
- Response port: rsp_valid clears on rsp_valid&&rsp_ready. rsp_data holds until the next capture.
- m_ack outside REQ/DROP is ignored.
- Reset mid-transfer: immediate return to reset values; FIFO contents lost.

## Timing
- Command pushed into an empty FIFO at cycle T is popped at T+1; cs_n falls at T+2.
- Requests assert at T+2+n_setup.
- If m_ack rises at cycle A: requests fall at A+1 and rsp_valid rises at A+1.
- If ack clears at cycle C: cs_n rises at C+1+n_hold, and the next pop occurs no earlier than C+1+n_hold+n_gap.
- Counters are 8-bit, count down, and are loaded on state entry. All outputs are registered.

## Configuration
- SPI_XFER_SEQ_TIMEOUT_EN defined:
  - A 32-bit counter runs in REQ. When it reaches TIMEOUT_CYC with no ack:
    - Requests deassert.
    - m_rst pulses for 1 cycle.
    - For a read command, rsp_valid=1, rsp_data=32'h0, rsp_err=1.
  - The FSM then proceeds to HOLD, skipping DROP.
- SPI_XFER_SEQ_TIMEOUT_EN undefined: REQ waits indefinitely; m_rst and rsp_err are tied 0.

## Test plan
- Write-only: n_setup=2, n_hold=3, n_gap=4, cmd_data=32'hA5A5_0001, model acks 10 cycles after request -> cs_n low exactly 2+11+1+3 cycles; m_wr_data stable; no rsp_valid.
- Read: cmd_rd=1, master returns 32'h1234_5678 with ack -> rsp_valid rises the cycle after ack with rsp_data=32'h1234_5678, rsp_err=0; holds until rsp_ready.
- Backpressure: two reads queued, rsp_ready=0 -> second transfer does not start (cs_n stays high) until the first response is consumed.
- FIFO full: push 5 commands with DEPTH=4 and no pops -> cmd_ready=0 after the 4th; the 5th is ignored; 4 transfers execute in order.
- Zero timing: n_setup=n_hold=n_gap=0 -> requests assert the same cycle cs_n falls; cs_n rises the cycle after ack clears.
- With SPI_XFER_SEQ_TIMEOUT_EN, TIMEOUT_CYC=20, no ack on a read -> requests drop after 20 cycles, m_rst pulses 1 cycle, rsp_err=1, rsp_data=0; the next command runs normally.

Source files
------------

// File: rtl/spi_xfer_seq.sv
// Command FIFO plus req/ack sequencer that frames each SPI-master transfer with cs_n.
// Optional request timeout/abort is enabled by defining SPI_XFER_SEQ_TIMEOUT_EN.
module spi_xfer_seq #(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic        cmd_rd,
    input  logic [31:0] cmd_data,
    input  logic [7:0]  n_setup,
    input  logic [7:0]  n_hold,
    input  logic [7:0]  n_gap,
    output logic        m_wr_req,
    output logic        m_rd_req,
    output logic [31:0] m_wr_data,
    input  logic        m_ack,
    input  logic [31:0] m_rd_data,
    output logic        m_rst,
    output logic        cs_n,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, SETUP, REQ, DROP, HOLD, GAP} state_t;

    // FIFO entry layout: {wr, rd, data}
    logic [33:0]   fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [33:0]   head;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    state_t     state_reg;
    logic [7:0] cnt_reg;
    logic       wr_reg;
    logic       rd_reg;

    state_t     post_state;
    logic [7:0] post_cnt;
    logic       post_cs_n;

    assign head       = fifo_mem[rd_ptr_reg];
    assign fifo_empty = (count_reg == '0);
    assign cmd_ready  = (count_reg != (AW+1)'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    // A read may only leave the FIFO once the response slot is free.
    assign pop        = (state_reg == IDLE) && !fifo_empty && !(head[32] && rsp_valid);
    assign busy       = (state_reg != IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {cmd_wr, cmd_rd, cmd_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + (AW+1)'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - (AW+1)'(1);
            end
        end
    end

    // Where the sequence goes once the master handshake is over (ack or abort).
    always_comb begin
        post_state = HOLD;
        post_cnt   = n_hold;
        post_cs_n  = 1'b0;
        if (n_hold == 8'd0) begin
            post_cs_n = 1'b1;
            if (n_gap == 8'd0) begin
                post_state = IDLE;
            end else begin
                post_state = GAP;
                post_cnt   = n_gap;
            end
        end
    end

`ifdef SPI_XFER_SEQ_TIMEOUT_EN
    logic [31:0] to_cnt_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
            wr_reg    <= 1'b0;
            rd_reg    <= 1'b0;
            cs_n      <= 1'b1;
            m_wr_req  <= 1'b0;
            m_rd_req  <= 1'b0;
            m_wr_data <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0;
`ifdef SPI_XFER_SEQ_TIMEOUT_EN
            to_cnt_reg <= 32'h0;
            m_rst      <= 1'b0;
            rsp_err    <= 1'b0;
`endif
        end else begin
`ifdef SPI_XFER_SEQ_TIMEOUT_EN
            m_rst <= 1'b0;
`endif
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    // Empty commands are popped and dropped without touching cs_n.
                    if (pop && (head[33] || head[32])) begin
                        wr_reg    <= head[33];
                        rd_reg    <= head[32];
                        cs_n      <= 1'b0;
                        m_wr_data <= head[31:0];
                        if (n_setup == 8'd0) begin
                            state_reg <= REQ;
                            m_wr_req  <= head[33];
                            m_rd_req  <= head[32];
`ifdef SPI_XFER_SEQ_TIMEOUT_EN
                            to_cnt_reg <= 32'h0;
`endif
                        end else begin
                            state_reg <= SETUP;
                            cnt_reg   <= n_setup;
                        end
                    end
                end
                SETUP: begin
                    if (cnt_reg == 8'd1) begin
                        state_reg <= REQ;
                        m_wr_req  <= wr_reg;
                        m_rd_req  <= rd_reg;
`ifdef SPI_XFER_SEQ_TIMEOUT_EN
                        to_cnt_reg <= 32'h0;
`endif
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                REQ: begin
                    if (m_ack) begin
                        m_wr_req  <= 1'b0;
                        m_rd_req  <= 1'b0;
                        state_reg <= DROP;
                        if (rd_reg) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= m_rd_data;
`ifdef SPI_XFER_SEQ_TIMEOUT_EN
                            rsp_err   <= 1'b0;
`endif
                        end
                    end
`ifdef SPI_XFER_SEQ_TIMEOUT_EN
                    else if (to_cnt_reg == 32'(TIMEOUT_CYC - 1)) begin
                        // Abort: kick the master and skip DROP, ack is never coming.
                        m_wr_req  <= 1'b0;
                        m_rd_req  <= 1'b0;
                        m_rst     <= 1'b1;
                        state_reg <= post_state;
                        cnt_reg   <= post_cnt;
                        cs_n      <= post_cs_n;
                        if (rd_reg) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= 32'h0;
                            rsp_err   <= 1'b1;
                        end
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 32'd1;
                    end
`endif
                end
                DROP: begin
                    if (!m_ack) begin
                        state_reg <= post_state;
                        cnt_reg   <= post_cnt;
                        cs_n      <= post_cs_n;
                    end
                end
                HOLD: begin
                    if (cnt_reg == 8'd1) begin
                        cs_n <= 1'b1;
                        if (n_gap == 8'd0) begin
                            state_reg <= IDLE;
                        end else begin
                            state_reg <= GAP;
                            cnt_reg   <= n_gap;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                GAP: begin
                    if (cnt_reg == 8'd1) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifndef SPI_XFER_SEQ_TIMEOUT_EN
    // Without the abort path there is no master reset and no error response;
    // TIMEOUT_CYC stays in the parameter list so both builds instantiate alike.
    assign m_rst   = (TIMEOUT_CYC < 0);
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Self-checking bench for spi_xfer_seq: directed and random commands against a
// transaction-level model of cs_n framing, request timing and read responses.
module tb_spi_xfer_seq;
    localparam int DEPTH = 4;
    localparam int TMO   = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic        cmd_rd = 1'b0;
    logic [31:0] cmd_data = 32'h0;
    logic [7:0]  n_setup = 8'd0;
    logic [7:0]  n_hold = 8'd0;
    logic [7:0]  n_gap = 8'd0;
    logic        m_wr_req, m_rd_req, m_rst, cs_n, rsp_valid, rsp_err, busy;
    logic [31:0] m_wr_data, rsp_data;
    logic        m_ack = 1'b0;
    logic [31:0] m_rd_data = 32'h0;
    logic        rsp_ready = 1'b0;

    always #5 clk = ~clk;

    spi_xfer_seq #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_rd(cmd_rd),
        .cmd_data(cmd_data), .n_setup(n_setup), .n_hold(n_hold), .n_gap(n_gap),
        .m_wr_req(m_wr_req), .m_rd_req(m_rd_req), .m_wr_data(m_wr_data),
        .m_ack(m_ack), .m_rd_data(m_rd_data), .m_rst(m_rst), .cs_n(cs_n),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy)
    );

    typedef struct {
        bit          wr, rd, from_idle;
        logic [31:0] data;
        int          push_cyc;
    } exp_t;

    typedef struct {
        bit          wr, rd, stable, rsp_err;
        logic [31:0] data, rsp_data;
        int          fall, req_start, setup_len, req_len, ack_cyc, rsp_cyc, cs_len, gap_before;
    } rec_t;

    exp_t        exps[$];
    rec_t        recs[$];
    logic [31:0] mdata[$];
    rec_t        cur;

    int n_total = 0, n_pass = 0, n_fail = 0;
    int cyc = 0;
    int ack_lat = 0, lat_cnt = 0, last_rise = 0, mrst_cnt = 0;
    bit prev_cs = 1'b1, prev_rv = 1'b0, in_xfer = 1'b0, req_seen = 1'b0, acked = 1'b0;
    bit no_ack = 1'b0, use_fixed = 1'b0;
    logic [31:0] fixed_val = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor (samples first) and master model (drives m_ack/m_rd_data) on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_cs = 1'b1; prev_rv = 1'b0; in_xfer = 1'b0; req_seen = 1'b0;
            acked = 1'b0; lat_cnt = 0; m_ack = 1'b0;
        end else begin
            if (m_rst) mrst_cnt++;
            if (prev_cs && !cs_n) begin
                cur = '{default: 0};
                cur.fall = cyc; cur.gap_before = cyc - last_rise;
                cur.ack_cyc = -1; cur.rsp_cyc = -1;
                in_xfer = 1'b1; req_seen = 1'b0;
            end
            if (in_xfer && (m_wr_req || m_rd_req)) begin
                if (!req_seen) begin
                    req_seen = 1'b1; cur.req_start = cyc; cur.setup_len = cyc - cur.fall;
                    cur.wr = m_wr_req; cur.rd = m_rd_req; cur.data = m_wr_data; cur.stable = 1'b1;
                end else if (m_wr_data !== cur.data || m_wr_req !== cur.wr || m_rd_req !== cur.rd) begin
                    cur.stable = 1'b0;
                end
                cur.req_len = cyc - cur.req_start + 1;
            end
            if (in_xfer && rsp_valid && !prev_rv) begin
                cur.rsp_cyc = cyc; cur.rsp_data = rsp_data; cur.rsp_err = rsp_err;
            end
            if (in_xfer && !prev_cs && cs_n) begin
                cur.cs_len = cyc - cur.fall; recs.push_back(cur);
                last_rise = cyc; in_xfer = 1'b0;
            end
            prev_cs = cs_n; prev_rv = rsp_valid;

            if (m_ack) begin
                m_ack = 1'b0;
            end else if ((m_wr_req || m_rd_req) && !acked && !no_ack) begin
                if (lat_cnt == ack_lat) begin
                    m_ack = 1'b1; acked = 1'b1;
                    m_rd_data = use_fixed ? fixed_val : $urandom;
                    mdata.push_back(m_rd_data);
                    cur.ack_cyc = cyc;
                end else begin
                    lat_cnt++;
                end
            end else if (!(m_wr_req || m_rd_req)) begin
                lat_cnt = 0; acked = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit wr, input bit rd, input logic [31:0] d, output bit acc);
        exp_t e;
        bit idle_now;
        idle_now  = (busy === 1'b0) && (rsp_valid === 1'b0);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_rd = rd; cmd_data = d;
        acc = (cmd_ready === 1'b1);
        if (acc && (wr || rd)) begin
            e.wr = wr; e.rd = rd; e.data = d; e.from_idle = idle_now; e.push_cyc = cyc;
            exps.push_back(e);
        end
        tick();
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_rd = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        for (int i = 0; i < 300 && rsp_valid !== 1'b1; i++) tick();
        chk({tag, " rsp_wait"}, 32'(rsp_valid), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000 && (busy !== 1'b0 || cs_n !== 1'b1); i++) tick();
        tick();
        chk({tag, " idle_wait"}, 32'(busy), 32'd0);
    endtask

    task automatic clear_model();
        exps.delete(); recs.delete(); mdata.delete();
    endtask

    // Compare every observed transfer against the command stream and timing rules.
    task automatic check_batch(input string tag);
        int n;
        rec_t r;
        exp_t e;
        logic [31:0] md;
        wait_idle(tag);
        chk({tag, " xfer_count"}, 32'(recs.size()), 32'(exps.size()));
        n = (recs.size() < exps.size()) ? recs.size() : exps.size();
        for (int i = 0; i < n; i++) begin
            r = recs[i]; e = exps[i];
            chk({tag, " wr_req"}, 32'(r.wr), 32'(e.wr));
            chk({tag, " rd_req"}, 32'(r.rd), 32'(e.rd));
            chk({tag, " wr_data"}, r.data, e.data);
            chk({tag, " wr_data_stable"}, 32'(r.stable), 32'd1);
            chk({tag, " setup_len"}, 32'(r.setup_len), 32'(int'(n_setup)));
            chk({tag, " req_len"}, 32'(r.req_len), 32'(ack_lat + 1));
            chk({tag, " cs_low_len"}, 32'(r.cs_len),
                32'(int'(n_setup) + ack_lat + 2 + int'(n_hold)));
            if (e.from_idle) chk({tag, " pop_latency"}, 32'(r.fall), 32'(e.push_cyc + 2));
            if (i > 0) chk({tag, " gap_ok"}, 32'(r.gap_before >= int'(n_gap) + 1), 32'd1);
            if (e.rd) begin
                md = (i < mdata.size()) ? mdata[i] : 32'hDEAD_BEEF;
                chk({tag, " rsp_rise"}, 32'(r.rsp_cyc), 32'(r.ack_cyc + 1));
                chk({tag, " rsp_data"}, r.rsp_data, md);
                chk({tag, " rsp_err"}, 32'(r.rsp_err), 32'd0);
            end else begin
                chk({tag, " no_rsp"}, 32'(r.rsp_cyc), 32'hFFFF_FFFF);
            end
        end
        $display("batch %s: %0d transfers observed, %0d expected", tag, recs.size(), exps.size());
        clear_model();
    endtask

    initial begin
        bit acc;
        int nacc;
        #2 rst = 1'b1;
        repeat (3) tick();
        chk("rst cs_n", 32'(cs_n), 32'd1);
        chk("rst m_wr_req", 32'(m_wr_req), 32'd0);
        chk("rst m_rd_req", 32'(m_rd_req), 32'd0);
        chk("rst m_wr_data", m_wr_data, 32'h0);
        chk("rst m_rst", 32'(m_rst), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_data", rsp_data, 32'h0);
        chk("rst rsp_err", 32'(rsp_err), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst cmd_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;
        repeat (2) tick();
        chk("post_rst cs_n", 32'(cs_n), 32'd1);

        // Write-only framing with slow master.
        n_setup = 8'd2; n_hold = 8'd3; n_gap = 8'd4; ack_lat = 10; rsp_ready = 1'b1;
        push(1'b1, 1'b0, 32'hA5A5_0001, acc);
        check_batch("write");

        // Read with fixed master data, response held under backpressure.
        ack_lat = 3; use_fixed = 1'b1; fixed_val = 32'h1234_5678; rsp_ready = 1'b0;
        push(1'b0, 1'b1, $urandom, acc);
        wait_rsp("read");
        chk("read rsp_data", rsp_data, 32'h1234_5678);
        chk("read rsp_err", 32'(rsp_err), 32'd0);
        repeat (5) tick();
        chk("read rsp_hold_valid", 32'(rsp_valid), 32'd1);
        chk("read rsp_hold_data", rsp_data, 32'h1234_5678);
        rsp_ready = 1'b1;
        tick();
        chk("read rsp_consumed", 32'(rsp_valid), 32'd0);
        chk("read rsp_data_kept", rsp_data, 32'h1234_5678);
        use_fixed = 1'b0;
        check_batch("read");

        // Two queued reads: second waits for the first response to be taken.
        rsp_ready = 1'b0; ack_lat = 2;
        push(1'b0, 1'b1, $urandom, acc);
        push(1'b0, 1'b1, $urandom, acc);
        wait_rsp("bp");
        repeat (30) tick();
        chk("bp one_xfer_only", 32'(recs.size()), 32'd1);
        chk("bp cs_n_high", 32'(cs_n), 32'd1);
        chk("bp busy", 32'(busy), 32'd1);
        rsp_ready = 1'b1;
        check_batch("bp");

        // Zero setup/hold/gap, including a discarded empty command.
        n_setup = 8'd0; n_hold = 8'd0; n_gap = 8'd0; ack_lat = 1;
        push(1'b1, 1'b0, $urandom, acc);
        push(1'b0, 1'b0, $urandom, acc);
        push(1'b0, 1'b1, $urandom, acc);
        push(1'b1, 1'b1, $urandom, acc);
        check_batch("zero");

        // FIFO full: a pending read response blocks pops while five pushes arrive.
        n_setup = 8'd1; n_hold = 8'd1; n_gap = 8'd1; ack_lat = 1; rsp_ready = 1'b0;
        push(1'b0, 1'b1, $urandom, acc);
        wait_rsp("full");
        wait_idle("full_pre");
        nacc = 0;
        for (int i = 0; i < 5; i++) begin
            push(1'b0, 1'b1, $urandom, acc);
            if (acc) nacc++;
            if (i == 3) chk("full cmd_ready_low", 32'(cmd_ready), 32'd0);
        end
        chk("full accepted", 32'(nacc), 32'(DEPTH));
        chk("full busy", 32'(busy), 32'd1);
        chk("full cs_n_high", 32'(cs_n), 32'd1);
        rsp_ready = 1'b1;
        check_batch("full");

        // Randomized batches.
        for (int b = 0; b < 4; b++) begin
            n_setup = 8'($urandom_range(0, 3));
            n_hold  = 8'($urandom_range(0, 3));
            n_gap   = 8'($urandom_range(0, 3));
            ack_lat = $urandom_range(0, 4);
            rsp_ready = 1'b1;
            for (int k = 0; k < 6; k++) begin
                bit w, r;
                w = 1'($urandom_range(0, 1));
                r = 1'($urandom_range(0, 1));
                for (int g = 0; g < 500 && cmd_ready !== 1'b1; g++) tick();
                push(w, r, $urandom, acc);
                repeat ($urandom_range(0, 3)) tick();
            end
            check_batch("random");
        end

        // Reset in the middle of a transfer with commands still queued.
        n_setup = 8'd2; n_hold = 8'd1; n_gap = 8'd1; ack_lat = 30;
        push(1'b1, 1'b0, $urandom, acc);
        push(1'b1, 1'b0, $urandom, acc);
        for (int i = 0; i < 100 && m_wr_req !== 1'b1; i++) tick();
        chk("midrst req_seen", 32'(m_wr_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst cs_n", 32'(cs_n), 32'd1);
        chk("midrst m_wr_req", 32'(m_wr_req), 32'd0);
        chk("midrst m_wr_data", m_wr_data, 32'h0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("midrst fifo_flushed", 32'(busy), 32'd0);
        chk("midrst cs_stays_high", 32'(cs_n), 32'd1);
        clear_model();

`ifdef SPI_XFER_SEQ_TIMEOUT_EN
        // Read with no ack: abort after TMO cycles, error response, then normal read.
        n_setup = 8'd1; n_hold = 8'd1; n_gap = 8'd1; no_ack = 1'b1; rsp_ready = 1'b0; mrst_cnt = 0;
        push(1'b0, 1'b1, $urandom, acc);
        wait_rsp("tmo");
        chk("tmo rsp_err", 32'(rsp_err), 32'd1);
        chk("tmo rsp_data", rsp_data, 32'h0);
        wait_idle("tmo");
        chk("tmo xfer_count", 32'(recs.size()), 32'd1);
        if (recs.size() > 0) begin
            chk("tmo req_len", 32'(recs[0].req_len), 32'(TMO));
            chk("tmo cs_low_len", 32'(recs[0].cs_len), 32'(1 + TMO + 1));
        end
        chk("tmo m_rst_pulses", 32'(mrst_cnt), 32'd1);
        rsp_ready = 1'b1;
        tick();
        clear_model();
        no_ack = 1'b0; ack_lat = 2;
        push(1'b0, 1'b1, $urandom, acc);
        check_batch("after_tmo");
`else
        chk("no_tmo m_rst_never", 32'(mrst_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
